// File: rtl/issue_queue_pkg.sv
// Shared types for the decode-to-issue queue: entry format, default depth, small helpers.
// Optional statistics build is selected with IQ_STAT_EN (see issue_queue).
package issue_queue_pkg;

  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } ISSUE_QUEUE_ELEMENT;

  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/issue_queue_ram.sv
// iq_ram: DEPTH-entry storage with two write lanes and two asynchronous read lanes.
// Latency: write lands on the rising edge, reads are combinational. No backpressure.
// Lane addresses are always distinct when both lanes write (consecutive slots).
module iq_ram
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we0,
  input  logic [AW-1:0]      waddr0,
  input  ISSUE_QUEUE_ELEMENT wdata0,
  input  logic               we1,
  input  logic [AW-1:0]      waddr1,
  input  ISSUE_QUEUE_ELEMENT wdata1,
  input  logic [AW-1:0]      raddr0,
  output ISSUE_QUEUE_ELEMENT rdata0,
  input  logic [AW-1:0]      raddr1,
  output ISSUE_QUEUE_ELEMENT rdata1
);

  ISSUE_QUEUE_ELEMENT mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/issue_queue.sv
// issue_queue: in-order dual-push / dual-pop queue between decode and issue; IQ_STAT_EN adds stat counters.
// Latency: push at edge N visible on issue_require in cycle N+1; outputs depend on registers only.
// Backpressure: iq_ready drops below two free slots and the whole offered push is then ignored.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flash,
  input  logic [1:0]                    push_number,
  input  ISSUE_QUEUE_ELEMENT [1:0]      push_data,
  output logic                          iq_ready,
  output ISSUE_QUEUE_ELEMENT [1:0]      issue_require,
  output logic [1:0]                    iq_size,
  input  logic [1:0]                    iq_pop_number,
  output logic [$clog2(DEPTH):0]        iq_count
`ifdef IQ_STAT_EN
  ,
  output logic [31:0]                   stat_full_cycles,
  output logic [31:0]                   stat_empty_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]      head, tail;
  logic [CW-1:0]      count;
  logic [1:0]         push_acc, pop_eff;
  logic               clear;
  logic               we0, we1;
  ISSUE_QUEUE_ELEMENT rd0, rd1;

  assign clear = !rst_n || flash;

  assign iq_count = count;
  assign iq_size  = (count >= CW'(2)) ? 2'd2 : count[1:0];
  // Ready looks at the registered count only, so a same-cycle pop never frees room for a push.
  assign iq_ready = (CW'(DEPTH) - count) >= CW'(2);

  // An out-of-range push_number of 3 is treated as 2, the most the write lanes can hold.
  assign push_acc = iq_ready ? min2(push_number, 2'd2) : 2'd0;
  assign pop_eff  = min2(iq_pop_number, iq_size);

  assign we0 = !clear && (push_acc != 2'd0);
  assign we1 = !clear && (push_acc == 2'd2);

  iq_ram #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk    (clk),
    .we0    (we0),
    .waddr0 (tail),
    .wdata0 (push_data[0]),
    .we1    (we1),
    .waddr1 (tail + PW'(1)),
    .wdata1 (push_data[1]),
    .raddr0 (head),
    .rdata0 (rd0),
    .raddr1 (head + PW'(1)),
    .rdata1 (rd1)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_eff);
      tail  <= tail + PW'(push_acc);
      count <= count + CW'(push_acc) - CW'(pop_eff);
    end
  end

  // Lanes past the occupancy read as a zero (nop) element.
  always_comb begin
    issue_require[0] = '0;
    issue_require[1] = '0;
    if (count >= CW'(1)) issue_require[0] = rd0;
    if (count >= CW'(2)) issue_require[1] = rd1;
  end

`ifdef IQ_STAT_EN
  // Counters survive flash; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_full_cycles  <= '0;
      stat_empty_cycles <= '0;
    end else begin
      if ((push_number != 2'd0) && !iq_ready) stat_full_cycles <= stat_full_cycles + 32'd1;
      if ((count == '0) && !flash)            stat_empty_cycles <= stat_empty_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue at DEPTH=8: vector table plus wrap, no-bypass and stat sequences.
module tb_issue_queue;
  import issue_queue_pkg::*;

  logic                     clk;
  logic                     rst_n;
  logic                     flash;
  logic [1:0]               push_number;
  ISSUE_QUEUE_ELEMENT [1:0] push_data;
  logic                     iq_ready;
  ISSUE_QUEUE_ELEMENT [1:0] issue_require;
  logic [1:0]               iq_size;
  logic [1:0]               iq_pop_number;
  logic [3:0]               iq_count;
`ifdef IQ_STAT_EN
  logic [31:0]              stat_full_cycles;
  logic [31:0]              stat_empty_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  issue_queue #(.DEPTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flash         (flash),
    .push_number   (push_number),
    .push_data     (push_data),
    .iq_ready      (iq_ready),
    .issue_require (issue_require),
    .iq_size       (iq_size),
    .iq_pop_number (iq_pop_number),
    .iq_count      (iq_count)
`ifdef IQ_STAT_EN
    ,
    .stat_full_cycles  (stat_full_cycles),
    .stat_empty_cycles (stat_empty_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag 0 stands for the all-zero (nop) element.
  function automatic ISSUE_QUEUE_ELEMENT mk(input int unsigned t);
    ISSUE_QUEUE_ELEMENT e;
    e = '0;
    if (t != 0) begin
      e.valid = 1'b1;
      e.pc    = t;
      e.inst  = t * 3 + 1;
      e.rd    = t[4:0];
      e.rs1   = t[5:1];
      e.rs2   = t[6:2];
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic [1:0] pn,
                       input int unsigned t0, input int unsigned t1, input logic [1:0] pop);
    rst_n         = r;
    flash         = f;
    push_number   = pn;
    push_data[0]  = mk(t0);
    push_data[1]  = mk(t1);
    iq_pop_number = pop;
  endtask

  typedef struct {
    logic        rst_n;
    logic        flash;
    logic [1:0]  push_n;
    int unsigned t0;
    int unsigned t1;
    logic [1:0]  pop;
    int          cnt;
    int          size;
    logic        rdy;
    int unsigned e0;
    int unsigned e1;
  } vec_t;

  localparam int NV = 25;
  vec_t vt [NV];

  initial begin
    // Expected columns describe the state just after the edge that applies the row.
    //          rst   fl  pn  t0  t1 pop cnt sz rdy e0  e1
    vt[0]  = '{1'b0, 0, 2,  90, 91, 0,  0, 0, 1,  0,  0};  // reset
    vt[1]  = '{1'b1, 0, 2,   1,  2, 0,  2, 2, 1,  1,  2};  // push A,B
    vt[2]  = '{1'b1, 0, 0,   0,  0, 1,  1, 1, 1,  2,  0};  // pop 1
    vt[3]  = '{1'b1, 0, 0,   0,  0, 1,  0, 0, 1,  0,  0};
    vt[4]  = '{1'b1, 0, 2,   3,  4, 0,  2, 2, 1,  3,  4};  // fill
    vt[5]  = '{1'b1, 0, 2,   5,  6, 0,  4, 2, 1,  3,  4};
    vt[6]  = '{1'b1, 0, 2,   7,  8, 0,  6, 2, 1,  3,  4};
    vt[7]  = '{1'b1, 0, 2,   9, 10, 0,  8, 2, 0,  3,  4};  // full
    vt[8]  = '{1'b1, 0, 2,  11, 12, 2,  6, 2, 1,  5,  6};  // push lost, pop 2
    vt[9]  = '{1'b1, 0, 0,   0,  0, 2,  4, 2, 1,  7,  8};
    vt[10] = '{1'b1, 0, 0,   0,  0, 2,  2, 2, 1,  9, 10};
    vt[11] = '{1'b1, 0, 0,   0,  0, 2,  0, 0, 1,  0,  0};
    vt[12] = '{1'b1, 0, 2,  20, 21, 0,  2, 2, 1, 20, 21};
    vt[13] = '{1'b1, 0, 1,  22, 99, 0,  3, 2, 1, 20, 21};
    vt[14] = '{1'b1, 1, 2,  30, 31, 2,  0, 0, 1,  0,  0};  // flash beats push/pop
    vt[15] = '{1'b1, 0, 2,  23, 24, 0,  2, 2, 1, 23, 24};
    vt[16] = '{1'b1, 0, 1,  25, 98, 0,  3, 2, 1, 23, 24};
    vt[17] = '{1'b0, 0, 2,  32, 33, 2,  0, 0, 1,  0,  0};  // reset beats push/pop
    vt[18] = '{1'b1, 0, 1,  26, 97, 0,  1, 1, 1, 26,  0};
    vt[19] = '{1'b1, 0, 0,   0,  0, 2,  0, 0, 1,  0,  0};  // over-pop clipped
    vt[20] = '{1'b1, 0, 2,  27, 28, 0,  2, 2, 1, 27, 28};
    vt[21] = '{1'b1, 0, 0,   0,  0, 2,  0, 0, 1,  0,  0};
    vt[22] = '{1'b1, 1, 2,  34, 35, 0,  0, 0, 1,  0,  0};  // held flash
    vt[23] = '{1'b1, 1, 2,  36, 37, 0,  0, 0, 1,  0,  0};
    vt[24] = '{1'b1, 0, 0,   0,  0, 0,  0, 0, 1,  0,  0};

    drive(1'b0, 1'b0, 2'd0, 0, 0, 2'd0);

`ifdef IQ_STAT_EN
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 0, 0, 2'd0);
    @(posedge clk); #1;
    chk("stat reset empty", 96'(stat_empty_cycles), 96'd0);
    chk("stat reset full", 96'(stat_full_cycles), 96'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 2'd0, 0, 0, 2'd0);
      @(posedge clk);
    end
    #1;
    chk("stat empty 5", 96'(stat_empty_cycles), 96'd5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 2'd2, 50 + 2 * i, 51 + 2 * i, 2'd0);
      @(posedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 2'd2, 60, 61, 2'd0);
      @(posedge clk);
    end
    #1;
    chk("stat full 3", 96'(stat_full_cycles), 96'd3);
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd0, 0, 0, 2'd0);
    @(posedge clk); #1;
    chk("stat full kept over flash", 96'(stat_full_cycles), 96'd3);
`endif

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].rst_n, vt[i].flash, vt[i].push_n, vt[i].t0, vt[i].t1, vt[i].pop);
      @(posedge clk); #1;
      chk($sformatf("v%0d count", i), 96'(iq_count), 96'(vt[i].cnt));
      chk($sformatf("v%0d size", i), 96'(iq_size), 96'(vt[i].size));
      chk($sformatf("v%0d ready", i), 96'(iq_ready), 96'(vt[i].rdy));
      chk($sformatf("v%0d req0", i), 96'(issue_require[0]), 96'(mk(vt[i].e0)));
      chk($sformatf("v%0d req1", i), 96'(issue_require[1]), 96'(mk(vt[i].e1)));
    end

    // No combinational push-to-issue path: before the edge nothing is visible yet.
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 40, 41, 2'd0);
    #1;
    chk("nobypass count", 96'(iq_count), 96'd0);
    chk("nobypass req0", 96'(issue_require[0]), 96'(mk(0)));
    @(posedge clk); #1;
    chk("after push req0", 96'(issue_require[0]), 96'(mk(40)));
    // Pop input must not change outputs until the edge.
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 0, 0, 2'd2);
    #1;
    chk("nopopbypass req0", 96'(issue_require[0]), 96'(mk(40)));
    @(posedge clk); #1;
    chk("after pop count", 96'(iq_count), 96'd0);

    // Steady push 2 / pop 2 across several pointer wraps.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 2'd2, 100 + 2 * k, 101 + 2 * k, 2'd2);
      @(posedge clk); #1;
      chk($sformatf("wrap%0d req0", k), 96'(issue_require[0]), 96'(mk(100 + 2 * k)));
      chk($sformatf("wrap%0d req1", k), 96'(issue_require[1]), 96'(mk(101 + 2 * k)));
      chk($sformatf("wrap%0d count", k), 96'(iq_count), 96'd2);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 0, 0, 2'd2);
    @(posedge clk); #1;
    chk("drain count", 96'(iq_count), 96'd0);
    chk("drain size", 96'(iq_size), 96'd0);

    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 0, 0, 2'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
